// File: rtl/accum_result_buffer_pkg.sv
// Shared types and defaults for the accumulator result path.
// The accumulator top, this buffer and the writeback stage all import these.
package accum_result_buffer_pkg;

  localparam int ACC_RES_DEPTH_DEFAULT = 8;
  localparam int ACC_TAG_BITS_DEFAULT  = 8;
  localparam int CPLX_W                = 16;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } complex_t;

  // A full FIFO can still take a push when the head leaves in the same cycle.
  function automatic logic push_accepted(input int unsigned count,
                                         input int unsigned depth,
                                         input logic        pop);
    return (count < depth) || pop;
  endfunction

endpackage

// File: rtl/accum_result_buffer_if.sv
// Result stream from the buffer to its consumer (writeback/DMA), valid/ready.
interface accum_result_buffer_if
  import accum_result_buffer_pkg::*;
#(
  parameter int TAG_BITS = ACC_TAG_BITS_DEFAULT
) ();

  complex_t            m_data;
  logic [TAG_BITS-1:0] m_tag;
  logic                m_valid;
  logic                m_ready;

  modport master (output m_data, output m_tag, output m_valid, input m_ready);
  modport slave  (input m_data, input m_tag, input m_valid, output m_ready);

endinterface

// File: rtl/accum_result_buffer_sync_fifo_complex.sv
// First-word-fall-through FIFO of {tag, complex_t}; head is presented combinationally.
module sync_fifo_complex
  import accum_result_buffer_pkg::*;
#(
  parameter int DEPTH    = ACC_RES_DEPTH_DEFAULT,
  parameter int TAG_BITS = ACC_TAG_BITS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [TAG_BITS-1:0]      i_push_tag,
  input  complex_t                 i_push_data,
  input  logic                     i_pop_req,
  output complex_t                 o_data,
  output logic [TAG_BITS-1:0]      o_tag,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_push_ok,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  complex_t            r_data_mem [DEPTH];
  logic [TAG_BITS-1:0] r_tag_mem  [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop_req && !w_empty;
  assign w_push  = i_push && push_accepted(32'(r_count), DEPTH, w_pop);

  // Pointers wrap naturally at DEPTH (power of two); count separates full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= i_push_data;
      r_tag_mem[r_wr_ptr]  <= i_push_tag;
    end
  end

  assign o_data    = w_empty ? '0 : r_data_mem[r_rd_ptr];
  assign o_tag     = w_empty ? '0 : r_tag_mem[r_rd_ptr];
  assign o_valid   = !w_empty;
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_push_ok = w_push;
  assign o_count   = r_count;

endmodule

// File: rtl/accum_result_buffer.sv
// Captures accumulator results one cycle after output_valid, tags them and
// queues them for the consumer; drops on a full queue are flagged by a sticky bit.
module accum_result_buffer
  import accum_result_buffer_pkg::*;
#(
  parameter int DEPTH    = ACC_RES_DEPTH_DEFAULT,
  parameter int TAG_BITS = ACC_TAG_BITS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  complex_t               acc_in,
  input  logic                   acc_valid_next,
  accum_result_buffer_if.master  m_if,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  logic                r_capture_pending;
  logic [TAG_BITS-1:0] r_tag;
  logic                r_overflow;

  logic                w_push_ok;
  logic                w_full;
  logic                w_drop;
  complex_t            w_head_data;
  logic [TAG_BITS-1:0] w_head_tag;
  logic                w_head_valid;

  sync_fifo_complex #(
    .DEPTH    (DEPTH),
    .TAG_BITS (TAG_BITS)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_capture_pending),
    .i_push_tag  (r_tag),
    .i_push_data (acc_in),
    .i_pop_req   (m_if.m_ready),
    .o_data      (w_head_data),
    .o_tag       (w_head_tag),
    .o_valid     (w_head_valid),
    .o_full      (w_full),
    .o_push_ok   (w_push_ok),
    .o_count     (count)
  );

  assign w_drop = r_capture_pending && !w_push_ok;

  // Dropped captures still consume a tag so the consumer sees the gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_capture_pending <= 1'b0;
      r_tag             <= '0;
      r_overflow        <= 1'b0;
    end else begin
      r_capture_pending <= acc_valid_next;
      if (r_capture_pending) r_tag <= r_tag + TAG_BITS'(1);
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  assign m_if.m_data  = w_head_data;
  assign m_if.m_tag   = w_head_tag;
  assign m_if.m_valid = w_head_valid;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_accum_result_buffer.sv
// Directed and scoreboarded checks of the accumulator result buffer.
module tb_accum_result_buffer;
  import accum_result_buffer_pkg::*;

  localparam int DEPTH    = 8;
  localparam int TAG_BITS = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       acc_valid_next;
  logic       clear_overflow;
  complex_t   acc_in;
  logic [3:0] count;
  logic       overflow;

  accum_result_buffer_if #(.TAG_BITS(TAG_BITS)) m_if ();

  accum_result_buffer #(
    .DEPTH    (DEPTH),
    .TAG_BITS (TAG_BITS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .acc_in         (acc_in),
    .acc_valid_next (acc_valid_next),
    .m_if           (m_if),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic complex_t cx(input int re, input int im);
    complex_t c;
    c.re = 16'(re);
    c.im = 16'(im);
    return c;
  endfunction

  task automatic check_head(input string name, input int re, input int im, input int tag);
    check({name, "_valid"}, 32'(m_if.m_valid), 32'd1);
    check({name, "_data"},  32'(m_if.m_data),  32'(cx(re, im)));
    check({name, "_tag"},   32'(m_if.m_tag),   32'(tag));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic avn;
    int   in_re;
    int   in_im;
    logic ready;
    logic e_valid;
    int   e_count;
    int   e_re;
    int   e_im;
    int   e_tag;
  } vec_t;

  vec_t vecs[12];

  typedef struct {
    complex_t            d;
    logic [TAG_BITS-1:0] t;
  } ent_t;

  ent_t q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic                pend;
    logic                ready;
    int                  issued;
    logic [TAG_BITS-1:0] exp_tag;
    logic                avn;

    // single result, then a 4-deep burst held off and drained
    vecs[0]  = '{1'b1, 0,  0, 1'b1, 1'b0, 0, 0,  0, 0};
    vecs[1]  = '{1'b0, 5, -3, 1'b1, 1'b1, 1, 5, -3, 0};
    vecs[2]  = '{1'b0, 0,  0, 1'b1, 1'b0, 0, 0,  0, 0};
    vecs[3]  = '{1'b1, 0,  0, 1'b0, 1'b0, 0, 0,  0, 0};
    vecs[4]  = '{1'b1, 1, -1, 1'b0, 1'b1, 1, 1, -1, 1};
    vecs[5]  = '{1'b1, 2, -2, 1'b0, 1'b1, 2, 1, -1, 1};
    vecs[6]  = '{1'b1, 3, -3, 1'b0, 1'b1, 3, 1, -1, 1};
    vecs[7]  = '{1'b0, 4, -4, 1'b0, 1'b1, 4, 1, -1, 1};
    vecs[8]  = '{1'b0, 0,  0, 1'b1, 1'b1, 3, 2, -2, 2};
    vecs[9]  = '{1'b0, 0,  0, 1'b1, 1'b1, 2, 3, -3, 3};
    vecs[10] = '{1'b0, 0,  0, 1'b1, 1'b1, 1, 4, -4, 4};
    vecs[11] = '{1'b0, 0,  0, 1'b1, 1'b0, 0, 0,  0, 0};

    reset          = 1'b1;
    acc_valid_next = 1'b0;
    clear_overflow = 1'b0;
    acc_in         = '0;
    m_if.m_ready   = 1'b0;
    tick();
    tick();
    check("rst_valid",    32'(m_if.m_valid), 32'd0);
    check("rst_count",    32'(count),        32'd0);
    check("rst_overflow", 32'(overflow),     32'd0);
    check("rst_data",     32'(m_if.m_data),  32'd0);
    check("rst_tag",      32'(m_if.m_tag),   32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      acc_valid_next = vecs[i].avn;
      acc_in         = cx(vecs[i].in_re, vecs[i].in_im);
      m_if.m_ready   = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(m_if.m_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_count", i), 32'(count),        32'(vecs[i].e_count));
      check($sformatf("vec%0d_ovf", i),   32'(overflow),     32'd0);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_data", i), 32'(m_if.m_data), 32'(cx(vecs[i].e_re, vecs[i].e_im)));
        check($sformatf("vec%0d_tag", i),  32'(m_if.m_tag),  32'(vecs[i].e_tag));
      end
    end

    // overflow: 10 captures into an 8-deep buffer
    pulse_reset();
    m_if.m_ready = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      acc_valid_next = (k < 10);
      acc_in         = cx(k, 100 + k);
      tick();
    end
    check("ovf_count", 32'(count),    32'd8);
    check("ovf_flag",  32'(overflow), 32'd1);
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("ovf_drain%0d", i), i + 1, 101 + i, i);
      tick();
    end
    check("ovf_empty",  32'(m_if.m_valid), 32'd0);
    check("ovf_sticky", 32'(overflow),     32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    m_if.m_ready   = 1'b0;
    acc_valid_next = 1'b1;
    tick();
    acc_valid_next = 1'b0;
    acc_in         = cx(42, -42);
    tick();
    check_head("ovf_gap_tag", 42, -42, 10);
    m_if.m_ready = 1'b1;
    tick();
    check("ovf_final_count", 32'(count), 32'd0);

    // full with simultaneous pop, then drop coinciding with clear
    pulse_reset();
    m_if.m_ready = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      acc_valid_next = (k < 8);
      acc_in         = cx(k, -k);
      tick();
    end
    check("full_count", 32'(count),    32'd8);
    check("full_ovf",   32'(overflow), 32'd0);
    acc_valid_next = 1'b1;
    acc_in         = '0;
    tick();
    acc_valid_next = 1'b0;
    acc_in         = cx(77, 7);
    m_if.m_ready   = 1'b1;
    tick();
    m_if.m_ready = 1'b0;
    check("fpop_count", 32'(count),    32'd8);
    check("fpop_ovf",   32'(overflow), 32'd0);
    check_head("fpop_head", 2, -2, 1);
    acc_valid_next = 1'b1;
    tick();
    acc_valid_next = 1'b0;
    acc_in         = cx(55, 5);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("setwins_ovf",   32'(overflow), 32'd1);
    check("setwins_count", 32'(count),    32'd8);
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check_head($sformatf("fpop_drain%0d", i), i + 2, -(i + 2), i + 1);
      tick();
    end
    check_head("fpop_last", 77, 7, 8);
    tick();
    check("fpop_empty", 32'(count), 32'd0);

    // reset mid-burst with a capture pending
    m_if.m_ready = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      acc_valid_next = 1'b1;
      acc_in         = cx(k, k);
      tick();
    end
    check("mid_count", 32'(count), 32'd5);
    reset          = 1'b1;
    acc_valid_next = 1'b1;
    acc_in         = cx(50, 50);
    tick();
    check("mid_rst_count", 32'(count),        32'd0);
    check("mid_rst_valid", 32'(m_if.m_valid), 32'd0);
    check("mid_rst_ovf",   32'(overflow),     32'd0);
    reset          = 1'b0;
    acc_valid_next = 1'b0;
    acc_in         = cx(123, 0);
    tick();
    check("mid_nocapture", 32'(count), 32'd0);
    acc_valid_next = 1'b1;
    tick();
    acc_valid_next = 1'b0;
    acc_in         = cx(9, -9);
    tick();
    check_head("mid_first", 9, -9, 0);
    m_if.m_ready = 1'b1;
    tick();
    check("mid_drained", 32'(count), 32'd0);

    // random backpressure against a scoreboard; next tag is 1
    pend    = 1'b0;
    issued  = 0;
    exp_tag = TAG_BITS'(1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (issued >= 100 && q.size() == 0 && !pend) break;
      check("bp_count", 32'(count),        32'(q.size()));
      check("bp_valid", 32'(m_if.m_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("bp_head_data", 32'(m_if.m_data), 32'(q[0].d));
        check("bp_head_tag",  32'(m_if.m_tag),  32'(q[0].t));
      end
      ready        = ($urandom_range(0, 3) != 0);
      m_if.m_ready = ready;
      if (ready && q.size() != 0) void'(q.pop_front());
      acc_in = cx(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      if (pend) begin
        q.push_back('{acc_in, exp_tag});
        exp_tag = exp_tag + TAG_BITS'(1);
      end
      avn            = (issued < 100) && (q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      acc_valid_next = avn;
      if (avn) issued++;
      pend = avn;
      tick();
    end
    check("bp_done", 32'(issued == 100 && q.size() == 0 && !pend), 32'd1);
    check("bp_no_ovf", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
